// File: rtl/mod_accum_pkg.sv
// rtl/mod_accum_pkg.sv - shared constants and helpers for the modular accumulator
package mod_accum_pkg;

    localparam int HIT_W_DEF = 8;
    localparam int MOD_MAX   = 256;

    // Bits needed to hold residues 0..n-1; never narrower than one bit (n=2 -> 1)
    function automatic int clog2_safe(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 31)
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mod_accum_fsm_if.sv
// rtl/mod_accum_fsm_if.sv - digit/result bundle for mod_accum_fsm (IN_SUB present with MOD_ACCUM_SUB_EN)
interface mod_accum_fsm_if #(
    parameter int IN_W  = 2,
    parameter int MOD   = 4,
    parameter int HIT_W = mod_accum_pkg::HIT_W_DEF
);
    localparam int STATE_W = mod_accum_pkg::clog2_safe(MOD);

    logic               IN_VALID;
    logic [IN_W-1:0]    IN_DATA;
    logic               CLR;
`ifdef MOD_ACCUM_SUB_EN
    logic               IN_SUB;
`endif
    logic               O;
    logic [STATE_W-1:0] STATE;
    logic               WRAP;
    logic [HIT_W-1:0]   HIT_CNT;

`ifdef MOD_ACCUM_SUB_EN
    modport master (output IN_VALID, IN_DATA, CLR, IN_SUB, input O, STATE, WRAP, HIT_CNT);
    modport slave  (input IN_VALID, IN_DATA, CLR, IN_SUB, output O, STATE, WRAP, HIT_CNT);
`else
    modport master (output IN_VALID, IN_DATA, CLR, input O, STATE, WRAP, HIT_CNT);
    modport slave  (input IN_VALID, IN_DATA, CLR, output O, STATE, WRAP, HIT_CNT);
`endif

endinterface

// File: rtl/mod_accum_fsm_mod_reduce.sv
// rtl/mod_accum_fsm_mod_reduce.sv - combinational reduction of a sum modulo MOD with wrap flag
module mod_reduce
    import mod_accum_pkg::*;
#(
    parameter int MOD   = 4,
    parameter int IN_W  = 3,
    parameter int RES_W = clog2_safe(MOD)
) (
    input  logic [IN_W-1:0]  sum,
    output logic [RES_W-1:0] residue,
    output logic             wrap
);

    // Work at 32 bits so MOD need not fit in IN_W (e.g. reducing a narrow digit)
    always_comb begin
        residue = RES_W'(32'(sum) % 32'(MOD));
        wrap    = (32'(sum) >= 32'(MOD));
    end

endmodule

// File: rtl/mod_accum_fsm.sv
// rtl/mod_accum_fsm.sv - modular accumulator with match output and hit counter; optional MOD_ACCUM_SUB_EN subtract path
module mod_accum_fsm
    import mod_accum_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int MOD   = 4,
    parameter int MATCH = 1,
    parameter int HIT_W = HIT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    mod_accum_fsm_if.slave    bus
);

    localparam int STATE_W = clog2_safe(MOD);
    // One spare bit so the raw sum never truncates before reduction
    localparam int SUM_W   = ((STATE_W > IN_W) ? STATE_W : IN_W) + 1;

    if (MOD < 2 || MOD > MOD_MAX) begin : g_bad_mod
        $fatal(1, "mod_accum_fsm: MOD=%0d out of range 2..%0d", MOD, MOD_MAX);
    end
    if (MATCH < 0 || MATCH >= MOD) begin : g_bad_match
        $fatal(1, "mod_accum_fsm: MATCH=%0d must be below MOD=%0d", MATCH, MOD);
    end
    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $fatal(1, "mod_accum_fsm: IN_W=%0d out of range 1..8", IN_W);
    end
    if (HIT_W < 1 || HIT_W > 31) begin : g_bad_hit_w
        $fatal(1, "mod_accum_fsm: HIT_W=%0d out of range 1..31", HIT_W);
    end

    logic [STATE_W-1:0] state_q;
    logic               wrap_q;
    logic [HIT_W-1:0]   hit_q;

    logic [SUM_W-1:0]   red_in;
    logic [STATE_W-1:0] next_state;
    logic               red_wrap;
    logic               next_wrap;

    mod_reduce #(
        .MOD  (MOD),
        .IN_W (SUM_W)
    ) u_reduce (
        .sum     (red_in),
        .residue (next_state),
        .wrap    (red_wrap)
    );

`ifdef MOD_ACCUM_SUB_EN
    logic [STATE_W-1:0] data_res;
    logic               data_wrap_unused;

    // Pre-reduce the digit so STATE + MOD - digit stays non-negative
    mod_reduce #(
        .MOD  (MOD),
        .IN_W (IN_W)
    ) u_reduce_data (
        .sum     (bus.IN_DATA),
        .residue (data_res),
        .wrap    (data_wrap_unused)
    );

    // Subtract reuses the main reducer; its wrap is set exactly when no borrow occurred
    always_comb begin
        red_in    = SUM_W'(state_q) + SUM_W'(bus.IN_DATA);
        next_wrap = red_wrap;
        if (bus.IN_SUB) begin
            red_in    = SUM_W'(state_q) + SUM_W'(MOD) - SUM_W'(data_res);
            next_wrap = ~red_wrap;
        end
    end
`else
    // Addition only: reduce STATE + digit at full width
    always_comb begin
        red_in    = SUM_W'(state_q) + SUM_W'(bus.IN_DATA);
        next_wrap = red_wrap;
    end
`endif

    // Residue, wrap pulse and hit counter: reset beats clear beats accept beats hold
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= '0;
            wrap_q  <= 1'b0;
            hit_q   <= '0;
        end else if (bus.CLR) begin
            state_q <= '0;
            wrap_q  <= 1'b0;
            hit_q   <= '0;
        end else if (bus.IN_VALID) begin
            state_q <= next_state;
            wrap_q  <= next_wrap;
            if (next_state == STATE_W'(MATCH)) begin
                hit_q <= HIT_W'(sat_inc(32'(hit_q), HIT_W));
            end
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign bus.O       = (state_q == STATE_W'(MATCH));
    assign bus.STATE   = state_q;
    assign bus.WRAP    = wrap_q;
    assign bus.HIT_CNT = hit_q;

endmodule
